// File: rtl/sdram_fifo_ctrl.sv
// sdram_fifo_ctrl: picks the next SDRAM burst (write first, then read) from
// FIFO fill levels, presents start address and length, and walks the write and
// read pointers through their frame windows as bursts complete.
module sdram_fifo_ctrl #(
   parameter int ADDR_W        = 24,
   parameter int RD_FIFO_DEPTH = 1024,
   parameter int WAIT_CLK      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sdram_init_done,
   input  logic [9:0]        wr_fifo_cnt,
   input  logic [9:0]        rd_fifo_cnt,
   input  logic [9:0]        wr_burst_len,
   input  logic [9:0]        rd_burst_len,
   input  logic [ADDR_W-1:0] wr_min_addr,
   input  logic [ADDR_W-1:0] wr_max_addr,
   input  logic [ADDR_W-1:0] rd_min_addr,
   input  logic [ADDR_W-1:0] rd_max_addr,
   input  logic              wr_load,
   input  logic              rd_load,
   input  logic              read_valid,
   input  logic              sdram_wr_ack,
   input  logic              sdram_rd_ack,
   output logic              sdram_wr_req,
   output logic              sdram_rd_req,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   output logic [9:0]        sdram_wr_burst,
   output logic [9:0]        sdram_rd_burst,
   output logic              wr_frame_done,
   output logic              rd_frame_done
);

   // Pointer arithmetic is one bit wider so addr + 2*burst never overflows.
   localparam int AW1 = ADDR_W + 1;
   localparam int WAIT_W = (WAIT_CLK > 1) ? $clog2(WAIT_CLK) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CLK > 0) ? WAIT_CLK - 1 : 0);
   localparam logic [31:0] RD_DEPTH_U = 32'(RD_FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_WAIT
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              init_d_reg;
   logic              init_done_reg;
   logic              wr_ack_d_reg;
   logic              rd_ack_d_reg;

   logic              init_rise;
   logic              wr_fall;
   logic              rd_fall;
   logic [9:0]        wr_len;
   logic [9:0]        rd_len;
   logic              wr_ready;
   logic              rd_ready;
   logic [AW1-1:0]    wr_nxt;
   logic [AW1-1:0]    wr_end;
   logic [AW1-1:0]    rd_nxt;
   logic [AW1-1:0]    rd_end;
   logic              wr_wrap;
   logic              rd_wrap;
   logic              wr_adv;
   logic              rd_adv;

   // Index 0 is the write-side load, index 1 the read-side load.
   logic [1:0]        load_in;
   logic [1:0]        load_pend;
   logic [1:0]        load_apply;

   assign init_rise = sdram_init_done & ~init_d_reg;
   assign wr_fall   = wr_ack_d_reg & ~sdram_wr_ack;
   assign rd_fall   = rd_ack_d_reg & ~sdram_rd_ack;

   // A zero burst length would stall the pointers, so it is promoted to one.
   assign wr_len = (wr_burst_len == 10'd0) ? 10'd1 : wr_burst_len;
   assign rd_len = (rd_burst_len == 10'd0) ? 10'd1 : rd_burst_len;

   assign wr_ready = init_done_reg && (wr_fifo_cnt >= wr_len);
   assign rd_ready = init_done_reg && read_valid &&
                     ((32'(rd_fifo_cnt) + 32'(rd_len)) <= RD_DEPTH_U);

   assign wr_nxt  = AW1'(sdram_wr_addr) + AW1'(sdram_wr_burst);
   assign wr_end  = wr_nxt + AW1'(sdram_wr_burst) - AW1'(1);
   assign wr_wrap = wr_end > AW1'(wr_max_addr);
   assign rd_nxt  = AW1'(sdram_rd_addr) + AW1'(sdram_rd_burst);
   assign rd_end  = rd_nxt + AW1'(sdram_rd_burst) - AW1'(1);
   assign rd_wrap = rd_end > AW1'(rd_max_addr);

   assign wr_adv = (state_reg == S_WR) && wr_fall;
   assign rd_adv = (state_reg == S_RD) && rd_fall;

   assign load_in    = {rd_load, wr_load};
   assign load_apply = (state_reg == S_IDLE) ? load_pend : 2'b00;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_load
         logic sync1_reg;
         logic sync2_reg;
         logic edge_reg;
         logic pend_reg;

         // Synchronise the foreign load level, catch its rising edge and hold
         // it pending until the FSM is idle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               edge_reg  <= 1'b0;
               pend_reg  <= 1'b0;
            end else begin
               sync1_reg <= load_in[gi];
               sync2_reg <= sync1_reg;
               edge_reg  <= sync2_reg;
               pend_reg  <= (pend_reg & ~load_apply[gi]) | (sync2_reg & ~edge_reg);
            end
         end

         assign load_pend[gi] = pend_reg;
      end
   endgenerate

   // Next-state logic: write has priority over read when both are ready.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (wr_ready) begin
               state_next = S_WR;
            end else if (rd_ready) begin
               state_next = S_RD;
            end
         end
         S_WR: begin
            if (wr_fall) begin
               state_next = S_WAIT;
            end
         end
         S_RD: begin
            if (rd_fall) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register, registered requests, burst capture and settle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         wait_cnt_reg   <= '0;
         init_d_reg     <= 1'b0;
         init_done_reg  <= 1'b0;
         wr_ack_d_reg   <= 1'b0;
         rd_ack_d_reg   <= 1'b0;
         sdram_wr_req   <= 1'b0;
         sdram_rd_req   <= 1'b0;
         sdram_wr_burst <= '0;
         sdram_rd_burst <= '0;
      end else begin
         state_reg    <= state_next;
         init_d_reg   <= sdram_init_done;
         wr_ack_d_reg <= sdram_wr_ack;
         rd_ack_d_reg <= sdram_rd_ack;
         sdram_wr_req <= (state_next == S_WR);
         sdram_rd_req <= (state_next == S_RD);
         if (init_rise) begin
            init_done_reg <= 1'b1;
         end
         if (state_reg == S_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         end else begin
            wait_cnt_reg <= '0;
         end
         if ((state_reg == S_IDLE) && (state_next == S_WR)) begin
            sdram_wr_burst <= wr_len;
         end
         if ((state_reg == S_IDLE) && (state_next == S_RD)) begin
            sdram_rd_burst <= rd_len;
         end
      end
   end

   // Write pointer: reload on init or pending load, otherwise advance on burst
   // completion and wrap to the window start when the next burst won't fit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdram_wr_addr <= '0;
         wr_frame_done <= 1'b0;
      end else begin
         wr_frame_done <= 1'b0;
         if (init_rise || load_apply[0]) begin
            sdram_wr_addr <= wr_min_addr;
         end else if (wr_adv) begin
            if (wr_wrap) begin
               sdram_wr_addr <= wr_min_addr;
               wr_frame_done <= 1'b1;
            end else begin
               sdram_wr_addr <= wr_nxt[ADDR_W-1:0];
            end
         end
      end
   end

   // Read pointer: same policy as the write pointer over the read window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdram_rd_addr <= '0;
         rd_frame_done <= 1'b0;
      end else begin
         rd_frame_done <= 1'b0;
         if (init_rise || load_apply[1]) begin
            sdram_rd_addr <= rd_min_addr;
         end else if (rd_adv) begin
            if (rd_wrap) begin
               sdram_rd_addr <= rd_min_addr;
               rd_frame_done <= 1'b1;
            end else begin
               sdram_rd_addr <= rd_nxt[ADDR_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// tb_sdram_fifo_ctrl: directed bench for sdram_fifo_ctrl with hand-computed
// expectations, stepped one clock at a time.
module tb_sdram_fifo_ctrl;

   localparam int ADDR_W = 24;

   logic              clk = 1'b0;
   logic              rst;
   logic              sdram_init_done;
   logic [9:0]        wr_fifo_cnt;
   logic [9:0]        rd_fifo_cnt;
   logic [9:0]        wr_burst_len;
   logic [9:0]        rd_burst_len;
   logic [ADDR_W-1:0] wr_min_addr;
   logic [ADDR_W-1:0] wr_max_addr;
   logic [ADDR_W-1:0] rd_min_addr;
   logic [ADDR_W-1:0] rd_max_addr;
   logic              wr_load;
   logic              rd_load;
   logic              read_valid;
   logic              sdram_wr_ack;
   logic              sdram_rd_ack;
   logic              sdram_wr_req;
   logic              sdram_rd_req;
   logic [ADDR_W-1:0] sdram_wr_addr;
   logic [ADDR_W-1:0] sdram_rd_addr;
   logic [9:0]        sdram_wr_burst;
   logic [9:0]        sdram_rd_burst;
   logic              wr_frame_done;
   logic              rd_frame_done;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   sdram_fifo_ctrl #(
      .ADDR_W        (ADDR_W),
      .RD_FIFO_DEPTH (1024),
      .WAIT_CLK      (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sdram_init_done (sdram_init_done),
      .wr_fifo_cnt     (wr_fifo_cnt),
      .rd_fifo_cnt     (rd_fifo_cnt),
      .wr_burst_len    (wr_burst_len),
      .rd_burst_len    (rd_burst_len),
      .wr_min_addr     (wr_min_addr),
      .wr_max_addr     (wr_max_addr),
      .rd_min_addr     (rd_min_addr),
      .rd_max_addr     (rd_max_addr),
      .wr_load         (wr_load),
      .rd_load         (rd_load),
      .read_valid      (read_valid),
      .sdram_wr_ack    (sdram_wr_ack),
      .sdram_rd_ack    (sdram_rd_ack),
      .sdram_wr_req    (sdram_wr_req),
      .sdram_rd_req    (sdram_rd_req),
      .sdram_wr_addr   (sdram_wr_addr),
      .sdram_rd_addr   (sdram_rd_addr),
      .sdram_wr_burst  (sdram_wr_burst),
      .sdram_rd_burst  (sdram_rd_burst),
      .wr_frame_done   (wr_frame_done),
      .rd_frame_done   (rd_frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) begin
         $display("[TB] ok %s = %0h", tag, obs);
      end else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_ack_pulse();
      sdram_wr_ack = 1'b1;
      tick();
      sdram_wr_ack = 1'b0;
      tick();
   endtask

   // The two requests must never be high together.
   always @(negedge clk) begin
      if (mon_en) begin
         n_tests++;
         assert ((sdram_wr_req & sdram_rd_req) === 1'b0) else begin
            n_fail++;
            $error("FAIL both_req: got wr=%b rd=%b, want not both", sdram_wr_req, sdram_rd_req);
         end
      end
   end

   initial begin
      rst = 1'b1;
      sdram_init_done = 1'b0;
      wr_fifo_cnt = '0;
      rd_fifo_cnt = '0;
      wr_burst_len = '0;
      rd_burst_len = '0;
      wr_min_addr = '0;
      wr_max_addr = '0;
      rd_min_addr = '0;
      rd_max_addr = '0;
      wr_load = 1'b0;
      rd_load = 1'b0;
      read_valid = 1'b0;
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_reqs", {28'd0, sdram_wr_req, sdram_rd_req, wr_frame_done, rd_frame_done}, 32'd0);
      chk("rst_wr_addr", 32'(sdram_wr_addr), 32'd0);
      chk("rst_rd_addr", 32'(sdram_rd_addr), 32'd0);
      chk("rst_bursts", {12'd0, sdram_wr_burst, sdram_rd_burst}, 32'd0);
      mon_en = 1'b1;

      // No request before init even with a full write FIFO
      rst = 1'b0;
      wr_min_addr = 24'd0;
      wr_max_addr = 24'd767;
      rd_min_addr = 24'h1000;
      rd_max_addr = 24'h1FFF;
      wr_burst_len = 10'd256;
      rd_burst_len = 10'd256;
      wr_fifo_cnt = 10'd256;
      tick();
      tick();
      tick();
      chk("pre_init_no_req", 32'(sdram_wr_req), 32'd0);

      // Init edge loads pointers, request follows
      sdram_init_done = 1'b1;
      tick();
      chk("init_no_req_yet", 32'(sdram_wr_req), 32'd0);
      chk("init_rd_addr", 32'(sdram_rd_addr), 32'h1000);
      tick();
      chk("wr1_req", 32'(sdram_wr_req), 32'd1);
      chk("wr1_burst", 32'(sdram_wr_burst), 32'd256);
      chk("wr1_addr", 32'(sdram_wr_addr), 32'd0);
      sdram_wr_ack = 1'b1;
      tick();
      sdram_wr_ack = 1'b0;
      chk("wr1_req_during_ack", 32'(sdram_wr_req), 32'd1);
      tick();
      chk("wr1_req_drop", 32'(sdram_wr_req), 32'd0);
      chk("wr1_addr_adv", 32'(sdram_wr_addr), 32'd256);
      chk("wr1_no_frame", 32'(wr_frame_done), 32'd0);
      tick();
      tick();
      chk("wr_gap_no_req", 32'(sdram_wr_req), 32'd0);
      tick();
      chk("wr2_req", 32'(sdram_wr_req), 32'd1);
      chk("wr2_addr", 32'(sdram_wr_addr), 32'd256);

      // Wrap: 0, 256, 512, then back to 0 with one frame_done
      wr_ack_pulse();
      chk("wr2_addr_adv", 32'(sdram_wr_addr), 32'd512);
      chk("wr2_no_frame", 32'(wr_frame_done), 32'd0);
      tick();
      tick();
      tick();
      chk("wr3_req", 32'(sdram_wr_req), 32'd1);
      wr_ack_pulse();
      chk("wr3_wrap_addr", 32'(sdram_wr_addr), 32'd0);
      chk("wr3_frame_done", 32'(wr_frame_done), 32'd1);
      tick();
      chk("wr3_frame_pulse_end", 32'(wr_frame_done), 32'd0);

      // Load applied in idle after the synchronizer delay
      wr_fifo_cnt = 10'd0;
      wr_max_addr = 24'd4095;
      wr_min_addr = 24'd512;
      wr_load = 1'b1;
      tick();
      tick();
      tick();
      chk("load_not_yet", 32'(sdram_wr_addr), 32'd0);
      tick();
      chk("load_applied", 32'(sdram_wr_addr), 32'd512);

      // Load arriving during a burst is deferred until idle
      wr_load = 1'b0;
      wr_fifo_cnt = 10'd256;
      tick();
      chk("wr4_req", 32'(sdram_wr_req), 32'd1);
      chk("wr4_addr", 32'(sdram_wr_addr), 32'd512);
      wr_load = 1'b1;
      wr_min_addr = 24'd1000;
      tick();
      tick();
      tick();
      sdram_wr_ack = 1'b1;
      tick();
      sdram_wr_ack = 1'b0;
      chk("load_deferred_in_wr", 32'(sdram_wr_addr), 32'd512);
      tick();
      chk("wr4_addr_adv", 32'(sdram_wr_addr), 32'd768);
      wr_fifo_cnt = 10'd0;
      tick();
      tick();
      chk("load_wait_state", 32'(sdram_wr_addr), 32'd768);
      tick();
      chk("load_after_idle", 32'(sdram_wr_addr), 32'd1000);
      wr_load = 1'b0;

      // Read threshold: 769 blocks, 768 requests
      rd_fifo_cnt = 10'd769;
      read_valid = 1'b1;
      tick();
      tick();
      tick();
      chk("rd_thresh_769", 32'(sdram_rd_req), 32'd0);
      rd_fifo_cnt = 10'd768;
      tick();
      chk("rd_thresh_768", 32'(sdram_rd_req), 32'd1);
      chk("rd1_no_wr", 32'(sdram_wr_req), 32'd0);
      chk("rd1_addr", 32'(sdram_rd_addr), 32'h1000);
      chk("rd1_burst", 32'(sdram_rd_burst), 32'd256);
      sdram_rd_ack = 1'b1;
      tick();
      tick();
      chk("rd1_req_hold", 32'(sdram_rd_req), 32'd1);
      tick();
      sdram_rd_ack = 1'b0;
      tick();
      chk("rd1_req_drop", 32'(sdram_rd_req), 32'd0);
      chk("rd1_addr_adv", 32'(sdram_rd_addr), 32'h1100);
      rd_fifo_cnt = 10'd1023;
      tick();
      tick();
      read_valid = 1'b0;
      rd_fifo_cnt = 10'd0;
      tick();
      tick();
      tick();
      tick();
      chk("rd_valid_low", 32'(sdram_rd_req), 32'd0);

      // Simultaneous thresholds: write first, read after the settle gap
      wr_fifo_cnt = 10'd300;
      read_valid = 1'b1;
      tick();
      chk("sim_wr_first", 32'(sdram_wr_req), 32'd1);
      chk("sim_rd_held", 32'(sdram_rd_req), 32'd0);
      chk("sim_wr_addr", 32'(sdram_wr_addr), 32'd1000);
      wr_ack_pulse();
      wr_fifo_cnt = 10'd0;
      chk("sim_wr_addr_adv", 32'(sdram_wr_addr), 32'd1256);
      tick();
      tick();
      chk("sim_rd_not_yet", 32'(sdram_rd_req), 32'd0);
      tick();
      chk("sim_rd_req", 32'(sdram_rd_req), 32'd1);
      chk("sim_rd_addr", 32'(sdram_rd_addr), 32'h1100);

      // Reset mid-burst clears outputs immediately
      rst = 1'b1;
      #1;
      chk("rst_mid_rd_req", 32'(sdram_rd_req), 32'd0);
      chk("rst_mid_rd_addr", 32'(sdram_rd_addr), 32'd0);
      chk("rst_mid_wr_addr", 32'(sdram_wr_addr), 32'd0);
      chk("rst_mid_rd_burst", 32'(sdram_rd_burst), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("reinit_no_req", 32'(sdram_rd_req), 32'd0);
      chk("reinit_rd_addr", 32'(sdram_rd_addr), 32'h1000);
      chk("reinit_wr_addr", 32'(sdram_wr_addr), 32'd1000);
      tick();
      chk("reinit_rd_req", 32'(sdram_rd_req), 32'd1);

      // Zero burst length behaves as one word
      sdram_rd_ack = 1'b1;
      tick();
      sdram_rd_ack = 1'b0;
      read_valid = 1'b0;
      tick();
      chk("rd2_addr_adv", 32'(sdram_rd_addr), 32'h1100);
      wr_burst_len = 10'd0;
      wr_fifo_cnt = 10'd1;
      tick();
      tick();
      tick();
      chk("len0_req", 32'(sdram_wr_req), 32'd1);
      chk("len0_burst", 32'(sdram_wr_burst), 32'd1);
      chk("len0_addr", 32'(sdram_wr_addr), 32'd1000);
      wr_fifo_cnt = 10'd0;
      wr_ack_pulse();
      chk("len0_addr_adv", 32'(sdram_wr_addr), 32'd1001);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
